uart_tx_flow: RTL and testbench

- 8N1 UART transmitter with an input FIFO and hardware flow control.
- Counterpart to the BNN receive path: takes response bytes from bnn_controller over a valid/ready handshake and serialises them onto UART_Tx.
- Starts a new frame only while the peer grants clearance on cts.

---
 rtl/uart_tx_flow.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_flow.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_flow.sv
// 8N1 UART transmitter fed by a small byte FIFO over valid/ready.
// A new frame starts only while the synchronised clear-to-send is high.
module uart_tx_flow #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic                          cts,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_buffer_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            r_cts_meta;
  logic            r_cts_sync;

  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;

  logic            w_push;
  logic            w_pop;
  logic            w_baud_done;
  logic            w_tx_d;

  assign data_ready      = (r_count != FULL_COUNT);
  assign tx_buffer_empty = (r_count == '0);
  assign fifo_count      = r_count;
  assign busy            = (r_state != IDLE);
  assign tx              = r_tx;

  assign w_push      = data_valid && data_ready;
  assign w_baud_done = (r_baud == BAUD_LAST);

  // Storage needs no reset: only entries below r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cts_meta <= 1'b0;
      r_cts_sync <= 1'b0;
    end else begin
      r_cts_meta <= cts;
      r_cts_sync <= r_cts_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_tx_d       = 1'b1;
    case (r_state)
      IDLE: begin
        if (!tx_buffer_empty && r_cts_sync) begin
          w_pop        = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        w_tx_d = 1'b0;
        if (w_baud_done) begin
          w_next_state = DATA;
        end
      end
      DATA: begin
        w_tx_d = r_shift[0];
        if (w_baud_done && (r_bit_idx == 3'd7)) begin
          w_next_state = STOP;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      if ((r_state == IDLE) || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + CW'(1);
      end

      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_baud_done) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
      end else if ((r_state == DATA) && w_baud_done) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end

      // Line level lags the state by one cycle so it is glitch-free.
      r_tx <= w_tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Scoreboard bench for uart_tx_flow: stimulus queues expected bytes,
// a line monitor decodes frames from tx and compares them in order.
module tb_uart_tx_flow;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       cts = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       tx_buffer_empty;
  logic [2:0] fifo_count;

  uart_tx_flow #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .cts            (cts),
    .tx             (tx),
    .busy           (busy),
    .tx_buffer_empty(tx_buffer_empty),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_done = 0;

  bit         mon_active = 1'b0;
  int         mon_t = 0;
  logic [7:0] mon_byte = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int get_start(input int idx);
    if (idx < start_q.size()) return start_q[idx];
    return -1000000;
  endfunction

  // Line monitor: decodes each frame mid-bit; reset abandons a partial frame.
  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_t++;
      if (mon_t == CPB / 2) begin
        check("start_bit", tx, 1'b0);
      end else if (mon_t >= CPB + CPB / 2 && mon_t < 9 * CPB && (mon_t % CPB) == CPB / 2) begin
        mon_byte[mon_t / CPB - 1] = tx;
      end else if (mon_t == 9 * CPB + CPB / 2) begin
        check("stop_bit", tx, 1'b1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got 0x%02h, expected no frame", mon_byte);
        end else begin
          check("frame_byte", mon_byte, exp_q.pop_front());
        end
        frames_done++;
      end
      if (mon_t == 10 * CPB - 1) mon_active = 1'b0;
    end
  end

  task automatic push_one(input logic [7:0] b, output int edge_cyc);
    data_in    = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    edge_cyc   = cyc;
    data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    for (int i = 0; i < budget && frames_done < target; i++) @(posedge clk);
    #1;
    check(name, frames_done, target);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    for (int i = 0; i < budget && start_q.size() < target; i++) @(posedge clk);
    #1;
    check(name, start_q.size() >= target, 1'b1);
  endtask

  int  pc, pc2, n0, f0, bc, cr, s0;
  bit  acc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", data_ready, 1'b1);
    check("rst_empty", tx_buffer_empty, 1'b1);
    check("rst_count", fifo_count, 3'd0);
    #2 rst = 1'b1;
    cts = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single byte: latency, bit pattern, busy width
    f0 = frames_done; n0 = start_q.size();
    exp_q.push_back(8'hA5);
    push_one(8'hA5, pc);
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    @(posedge clk);
    #1;
    check("single_busy_cycles", bc, 40);
    wait_frames(f0 + 1, 100, "single_frame_done");
    check("single_latency", get_start(n0) - pc, 2);

    // Back-to-back 0x00 then 0xFF
    f0 = frames_done; n0 = start_q.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    push_one(8'h00, pc);
    push_one(8'hFF, pc2);
    wait_starts(n0 + 2, 150, "b2b_second_start");
    check("b2b_empty_after_pop", tx_buffer_empty, 1'b1);
    check("b2b_count_after_pop", fifo_count, 3'd0);
    wait_frames(f0 + 2, 150, "b2b_frames_done");
    check("b2b_period", get_start(n0 + 1) - get_start(n0), 41);

    // Full FIFO while cts is withheld
    cts = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    f0 = frames_done;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i * 8'h11));
      push_one(8'(i * 8'h11), pc);
    end
    check("fill3_ready", data_ready, 1'b1);
    check("fill3_count", fifo_count, 3'd3);
    exp_q.push_back(8'h44);
    push_one(8'h44, pc);
    check("full_ready", data_ready, 1'b0);
    check("full_count", fifo_count, 3'd4);
    check("full_not_empty", tx_buffer_empty, 1'b0);
    push_one(8'h55, pc);
    check("full_drop_count", fifo_count, 3'd4);
    check("full_drop_ready", data_ready, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    check("full_held_by_cts", frames_done, f0);
    cts = 1'b1;
    wait_frames(f0 + 4, 4 * 41 + 20, "full_frames_done");
    repeat (60) @(posedge clk);
    #1;
    check("full_no_extra_frame", frames_done, f0 + 4);
    check("full_drained", tx_buffer_empty, 1'b1);
    check("full_scoreboard_empty", exp_q.size(), 0);

    // cts drop mid-frame
    f0 = frames_done; n0 = start_q.size();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h99);
    push_one(8'h3C, pc);
    push_one(8'h99, pc2);
    wait_starts(n0 + 1, 20, "flow_first_start");
    s0 = get_start(n0);
    for (int i = 0; i < 40 && cyc < s0 + 4 * 4 + 2; i++) @(posedge clk);
    #1;
    cts = 1'b0;
    wait_frames(f0 + 1, 100, "flow_first_done");
    repeat (40) @(posedge clk);
    #1;
    check("flow_held_frames", frames_done, f0 + 1);
    check("flow_held_starts", start_q.size(), n0 + 1);
    check("flow_held_count", fifo_count, 3'd1);
    check("flow_held_busy", busy, 1'b0);
    cts = 1'b1;
    cr  = cyc;
    wait_starts(n0 + 2, 40, "flow_second_start");
    check("flow_cts_latency_ge3", (get_start(n0 + 1) - cr) >= 3, 1'b1);
    wait_frames(f0 + 2, 100, "flow_second_done");

    // Reset mid-frame aborts the frame and flushes the FIFO
    f0 = frames_done; n0 = start_q.size();
    push_one(8'h5A, pc);
    push_one(8'h6B, pc2);
    wait_starts(n0 + 1, 20, "rstmid_start");
    repeat (15) @(posedge clk);
    #1;
    check("rstmid_pre_busy", busy, 1'b1);
    check("rstmid_pre_count", fifo_count, 3'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_count", fifo_count, 3'd0);
    check("rstmid_ready", data_ready, 1'b1);
    check("rstmid_empty", tx_buffer_empty, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_frame", frames_done, f0);
    exp_q.push_back(8'h77);
    push_one(8'h77, pc);
    wait_frames(f0 + 1, 100, "rstmid_after_frame");

    // Streaming through pointer wrap
    f0 = frames_done;
    for (int i = 1; i <= 10; i++) begin
      data_in    = 8'(i);
      data_valid = 1'b1;
      acc        = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        acc = data_ready;
        @(posedge clk);
        #1;
      end
      data_valid = 1'b0;
      check("wrap_push_accepted", acc, 1'b1);
      if (acc) exp_q.push_back(8'(i));
    end
    wait_frames(f0 + 10, 10 * 41 + 100, "wrap_frames_done");
    check("wrap_drained", tx_buffer_empty, 1'b1);
    check("wrap_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
